// File: rtl/vblank_scheduler.sv
// vblank_scheduler
//   Shares the vertical-blanking update window between N_REQ game-logic
//   requesters. Each requester gets at most one round-robin slot per frame,
//   every slot is bounded by TIMEOUT cycles, and any grant still held when
//   active video resumes is revoked.
//
// Ports
//   clk_pix        pixel clock
//   rst_pix        synchronous active-high reset
//   sx, sy         raster position from dvi_controller
//   req_i          level request per requester
//   done_i         one-cycle completion pulse from the granted requester
//   win_o          update window open
//   frame_start_o  one-cycle pulse when the window opens
//   grant_o        one-hot grant, all-zero when nobody holds the window
//   grant_idx_o    index of the current or most recent grant
//   timeout_o      one-cycle pulse when a grant is dropped for timeout
//   overrun_o      one-cycle pulse when a grant is revoked at window close
//   frame_cnt_o    frames seen, wrapping
module vblank_scheduler #(
  parameter int CORDW   = 10,
  parameter int N_REQ   = 4,
  parameter int V_RES   = 480,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk_pix,
  input  logic                       rst_pix,
  input  logic [CORDW-1:0]           sx,
  input  logic [CORDW-1:0]           sy,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ-1:0]           done_i,
  output logic                       win_o,
  output logic                       frame_start_o,
  output logic [N_REQ-1:0]           grant_o,
  output logic [$clog2(N_REQ)-1:0]   grant_idx_o,
  output logic                       timeout_o,
  output logic                       overrun_o,
  output logic [15:0]                frame_cnt_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARB, GRANT, DRAIN} state_t;

  state_t           state;
  logic [N_REQ-1:0] elig;
  logic [IW-1:0]    ptr;
  logic [TW-1:0]    tcnt;

  logic             open_cond;
  logic             close_cond;
  logic [IW:0]      pick;

  // Index following i, wrapping at N_REQ (which need not be a power of two).
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (i == IW'(N_REQ - 1)) return '0;
    return i + IW'(1);
  endfunction

  // Round-robin search: first set bit of cand at or above start, wrapping.
  // Returns {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] cand,
                                          input logic [IW-1:0]    start);
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(start) + i) % N_REQ;
      if (!found && cand[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

  assign open_cond  = (sx == '0) && (sy == CORDW'(V_RES));
  assign close_cond = (sy < CORDW'(V_RES));
  // Requesters that dropped req since the window opened forfeit their slot.
  assign pick       = rr_pick(elig & req_i, ptr);

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state         <= IDLE;
      elig          <= '0;
      ptr           <= '0;
      tcnt          <= '0;
      win_o         <= 1'b0;
      frame_start_o <= 1'b0;
      grant_o       <= '0;
      grant_idx_o   <= '0;
      timeout_o     <= 1'b0;
      overrun_o     <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      frame_start_o <= 1'b0;
      timeout_o     <= 1'b0;
      overrun_o     <= 1'b0;

      // Active video resuming overrides everything, including a timeout
      // that would otherwise fire in this same cycle.
      if (state != IDLE && close_cond) begin
        state   <= IDLE;
        win_o   <= 1'b0;
        grant_o <= '0;
        elig    <= '0;
        if (grant_o != '0) begin
          ptr <= next_idx(grant_idx_o);
          // A done landing on the closing cycle is a normal completion.
          if (!done_i[grant_idx_o]) overrun_o <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (open_cond) begin
              state         <= ARB;
              win_o         <= 1'b1;
              frame_start_o <= 1'b1;
              frame_cnt_o   <= frame_cnt_o + 16'd1;
              elig          <= req_i;
            end
          end

          ARB: begin
            if (pick[IW]) begin
              state       <= GRANT;
              grant_o     <= N_REQ'(1) << pick[IW-1:0];
              grant_idx_o <= pick[IW-1:0];
              tcnt        <= '0;
            end else begin
              state <= DRAIN;
            end
          end

          GRANT: begin
            // tcnt holds (granted cycles so far - 1); done in the last
            // granted cycle is checked first so it wins over timeout.
            if (done_i[grant_idx_o]) begin
              state             <= ARB;
              grant_o           <= '0;
              elig[grant_idx_o] <= 1'b0;
              ptr               <= next_idx(grant_idx_o);
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
              state             <= ARB;
              grant_o           <= '0;
              elig[grant_idx_o] <= 1'b0;
              ptr               <= next_idx(grant_idx_o);
              timeout_o         <= 1'b1;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end

          DRAIN: begin
            // Window stays open with nobody granted until close.
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vblank_scheduler.sv
module tb_vblank_scheduler;

  localparam int CORDW   = 10;
  localparam int N_REQ   = 4;
  localparam int V_RES   = 480;
  localparam int TIMEOUT = 16;

  logic             clk_pix;
  logic             rst_pix;
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] done_i;
  logic             win_o;
  logic             frame_start_o;
  logic [N_REQ-1:0] grant_o;
  logic [1:0]       grant_idx_o;
  logic             timeout_o;
  logic             overrun_o;
  logic [15:0]      frame_cnt_o;

  int vectors = 0;
  int errors  = 0;

  logic [N_REQ-1:0] exp_q[$];
  logic [N_REQ-1:0] prev_grant = '0;

  vblank_scheduler #(
    .CORDW(CORDW), .N_REQ(N_REQ), .V_RES(V_RES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_pix       (clk_pix),
    .rst_pix       (rst_pix),
    .sx            (sx),
    .sy            (sy),
    .req_i         (req_i),
    .done_i        (done_i),
    .win_o         (win_o),
    .frame_start_o (frame_start_o),
    .grant_o       (grant_o),
    .grant_idx_o   (grant_idx_o),
    .timeout_o     (timeout_o),
    .overrun_o     (overrun_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every new grant must match the next expected one-hot.
  always @(negedge clk_pix) begin
    if (grant_o != '0 && prev_grant == '0) begin
      if (exp_q.size() == 0) check("sb_extra", 32'(grant_o), 32'd0);
      else                   check("sb_grant", 32'(grant_o), 32'(exp_q.pop_front()));
    end
    prev_grant = grant_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  // Advance n edges; inputs changed afterwards are sampled at the next edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_pix);
    #1;
  endtask

  task automatic reset_dut();
    rst_pix = 1'b1;
    tick(2);
    rst_pix = 1'b0;
  endtask

  task automatic open_window(input int exp_cnt);
    sx = '0;
    sy = CORDW'(V_RES);
    tick();
    check("open_win", 32'(win_o), 32'd1);
    check("open_fs", 32'(frame_start_o), 32'd1);
    check("open_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
    sx = CORDW'(1);
    tick();
    check("fs_pulse", 32'(frame_start_o), 32'd0);
  endtask

  task automatic close_window();
    sx = '0;
    sy = '0;
    tick();
    check("close_win", 32'(win_o), 32'd0);
    check("close_grant", 32'(grant_o), 32'd0);
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (grant_o == '0 && n < 50) begin
      tick();
      n++;
    end
    if (grant_o == '0) check("grant_wait", 32'd0, 32'd1);
  endtask

  // Serve n grants in turn, each completed after `hold` granted cycles.
  task automatic serve(input int n, input int hold);
    for (int k = 0; k < n; k++) begin
      wait_grant();
      tick(hold - 1);
      done_i = grant_o;
      tick();
      done_i = '0;
      check("done_drop", 32'(grant_o), 32'd0);
      tick();
      if (k < n - 1) check("gap2", 32'(grant_o != '0), 32'd1);
      else           check("drain", 32'(grant_o), 32'd0);
    end
  endtask

  initial begin
    int cnt;
    rst_pix = 1'b0;
    sx      = '0;
    sy      = '0;
    req_i   = '0;
    done_i  = '0;
    reset_dut();
    check("rst_win", 32'(win_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_idx", 32'(grant_idx_o), 32'd0);
    check("rst_cnt", 32'(frame_cnt_o), 32'd0);
    check("rst_pulses", {29'd0, frame_start_o, timeout_o, overrun_o}, 32'd0);

    // Basic round-robin: 0,1,2,3.
    req_i = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    open_window(1);
    check("first_idx", 32'(grant_idx_o), 32'd0);
    serve(4, 10);
    tick(3);
    check("drain_win", 32'(win_o), 32'd1);
    req_i = '0;
    close_window();
    check("close_ovr", 32'(overrun_o), 32'd0);
    check("sb_empty1", 32'(exp_q.size()), 32'd0);
    tick(3);

    // Fairness across frames: pointer persists.
    req_i = 4'b0110;
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    open_window(2);
    serve(2, 3);
    close_window();
    tick(2);
    req_i = 4'b1111;
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    open_window(3);
    serve(4, 2);
    req_i = '0;
    close_window();
    check("sb_empty2", 32'(exp_q.size()), 32'd0);
    tick(2);

    // Timeout: requester 0 never completes.
    reset_dut();
    req_i = 4'b0011;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    open_window(1);
    wait_grant();
    cnt = 1;
    while (grant_o == 4'b0001 && cnt < 100) begin
      tick();
      if (grant_o == 4'b0001) cnt++;
    end
    check("to_len", 32'(cnt), 32'(TIMEOUT));
    check("to_pulse", 32'(timeout_o), 32'd1);
    check("to_grant0", 32'(grant_o), 32'd0);
    tick();
    check("to_once", 32'(timeout_o), 32'd0);
    check("to_next", 32'(grant_o), 32'b0010);
    done_i = 4'b0010;
    tick();
    done_i = '0;
    tick();
    check("to_drain", 32'(grant_o), 32'd0);
    req_i = '0;
    close_window();
    tick(2);

    // Window close while granted: overrun, then done coincident with close.
    reset_dut();
    req_i = 4'b0100;
    exp_q.push_back(4'b0100);
    open_window(1);
    wait_grant();
    tick(4);
    sx = '0;
    sy = '0;
    tick();
    check("ovr_pulse", 32'(overrun_o), 32'd1);
    check("ovr_grant", 32'(grant_o), 32'd0);
    check("ovr_win", 32'(win_o), 32'd0);
    tick();
    check("ovr_once", 32'(overrun_o), 32'd0);
    exp_q.push_back(4'b0100);
    open_window(2);
    wait_grant();
    tick(4);
    sx = '0;
    sy = '0;
    done_i = 4'b0100;
    tick();
    done_i = '0;
    check("done_close_ovr", 32'(overrun_o), 32'd0);
    check("done_close_grant", 32'(grant_o), 32'd0);
    check("done_close_win", 32'(win_o), 32'd0);
    req_i = '0;
    tick(2);

    // Request withdrawal and stray done.
    reset_dut();
    req_i = 4'b0011;
    exp_q.push_back(4'b0001);
    open_window(1);
    wait_grant();
    req_i = 4'b0001;
    done_i = 4'b1000;
    tick();
    done_i = '0;
    check("stray_grant", 32'(grant_o), 32'b0001);
    check("stray_to", 32'(timeout_o), 32'd0);
    tick(2);
    done_i = 4'b0001;
    tick();
    done_i = '0;
    tick(5);
    check("wd_drain", 32'(grant_o), 32'd0);
    check("wd_win", 32'(win_o), 32'd1);
    check("sb_empty3", 32'(exp_q.size()), 32'd0);
    req_i = '0;
    close_window();
    tick(2);

    // Reset mid-grant: pointer is 1 here, so index 1 is granted first.
    req_i = 4'b1111;
    exp_q.push_back(4'b0010);
    open_window(2);
    wait_grant();
    tick(3);
    rst_pix = 1'b1;
    tick();
    rst_pix = 1'b0;
    check("mid_rst_grant", 32'(grant_o), 32'd0);
    check("mid_rst_win", 32'(win_o), 32'd0);
    check("mid_rst_cnt", 32'(frame_cnt_o), 32'd0);
    check("mid_rst_pulses", {30'd0, timeout_o, overrun_o}, 32'd0);
    sx = '0;
    sy = '0;
    tick(2);
    exp_q.push_back(4'b0001);
    open_window(1);
    wait_grant();
    check("post_rst_idx", 32'(grant_idx_o), 32'd0);
    req_i = '0;
    close_window();
    check("sb_empty4", 32'(exp_q.size()), 32'd0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
